// File: rtl/glip_uart_tx_framer.sv
// Word-to-byte framer feeding the UART transmitter: high byte first, ESCAPE doubling, credit frames between words.
// Optional statistics counters are enabled with `define GLIP_UART_TX_FRAMER_STATS_EN.
module glip_uart_tx_framer #(
    parameter logic [7:0] ESCAPE      = 8'hFE,
    parameter logic [7:0] CTRL_CREDIT = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] credit_val,
    input  logic        credit_req,
    output logic        credit_ack,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_done
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
    ,
    output logic [31:0] stat_words,
    output logic [15:0] stat_escapes
`endif
);

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned CREDIT_W = 15;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_HI, S_HI_E, S_LO, S_LO_E, S_C_ESC, S_C_CMD, S_C_HI, S_C_LO
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   word, word_nxt;
    logic [CREDIT_W-1:0] credit, credit_nxt;
    logic [BYTE_W-1:0]   data_nxt;

    // Next state, holding registers and the byte to present in the next state.
    always_comb begin
        state_nxt  = state;
        word_nxt   = word;
        credit_nxt = credit;
        data_nxt   = tx_data;
        in_ready   = 1'b0;
        credit_ack = 1'b0;

        case (state)
            S_IDLE: begin
                if (credit_req) begin
                    credit_ack = 1'b1;
                    credit_nxt = credit_val;
                    state_nxt  = S_C_ESC;
                end else if (in_valid) begin
                    in_ready  = 1'b1;
                    word_nxt  = in_data;
                    state_nxt = S_HI;
                end
            end
            S_HI:    if (tx_done) state_nxt = (word[15:8] == ESCAPE) ? S_HI_E : S_LO;
            S_HI_E:  if (tx_done) state_nxt = S_LO;
            S_LO:    if (tx_done) state_nxt = (word[7:0] == ESCAPE) ? S_LO_E : S_IDLE;
            S_LO_E:  if (tx_done) state_nxt = S_IDLE;
            S_C_ESC: if (tx_done) state_nxt = S_C_CMD;
            S_C_CMD: if (tx_done) state_nxt = S_C_HI;
            S_C_HI:  if (tx_done) state_nxt = S_C_LO;
            S_C_LO:  if (tx_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Credit bytes go out raw; the receiver knows the frame length.
        case (state_nxt)
            S_HI:                     data_nxt = word_nxt[15:8];
            S_LO:                     data_nxt = word_nxt[7:0];
            S_HI_E, S_LO_E, S_C_ESC:  data_nxt = ESCAPE;
            S_C_CMD:                  data_nxt = CTRL_CREDIT;
            S_C_HI:                   data_nxt = {1'b0, credit_nxt[14:8]};
            S_C_LO:                   data_nxt = credit_nxt[7:0];
            default:                  data_nxt = tx_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            word      <= '0;
            credit    <= '0;
            tx_data   <= '0;
            tx_enable <= 1'b0;
        end else begin
            state     <= state_nxt;
            word      <= word_nxt;
            credit    <= credit_nxt;
            tx_data   <= data_nxt;
            tx_enable <= (state_nxt != S_IDLE);
        end
    end

`ifdef GLIP_UART_TX_FRAMER_STATS_EN
    localparam int unsigned WORDS_CNT_W = 32;
    localparam int unsigned ESC_CNT_W   = 16;

    logic word_done;
    logic esc_done;

    // A word completes when its final byte (LO or its escape) is acknowledged.
    assign word_done = tx_done && (state_nxt == S_IDLE) && (state == S_LO || state == S_LO_E);
    assign esc_done  = tx_done && (state == S_HI_E || state == S_LO_E);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_words   <= '0;
            stat_escapes <= '0;
        end else begin
            if (word_done && (stat_words != '1))
                stat_words <= stat_words + WORDS_CNT_W'(1);
            if (esc_done && (stat_escapes != '1))
                stat_escapes <= stat_escapes + ESC_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_glip_uart_tx_framer.sv
// Directed self-checking bench for glip_uart_tx_framer.
module tb_glip_uart_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] credit_val;
    logic        credit_req;
    logic        credit_ack;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_done;
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_escapes;
`endif

    int checks   = 0;
    int failures = 0;

    glip_uart_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .credit_val (credit_val),
        .credit_req (credit_req),
        .credit_ack (credit_ack),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_done    (tx_done)
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_escapes (stat_escapes)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects byte exp on the transmitter now; holds it for 'hold' cycles, then returns tx_done.
    task automatic do_byte(input string tag, input logic [7:0] exp, input int hold);
        chk({tag, "_en"}, 32'(tx_enable), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        chk({tag, "_hs"}, 32'({in_ready, credit_ack}), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold"}, 32'({tx_enable, tx_data, in_ready, credit_ack}),
                32'({1'b1, exp, 2'b00}));
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    // Offers one word in IDLE and expects it to be taken immediately.
    task automatic send_word(input string tag, input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_no_ack"}, 32'(credit_ack), 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        credit_val = '0;
        credit_req = 1'b0;
        tx_done    = 1'b0;

        #12;
        chk("reset_en", 32'(tx_enable), 32'd0);
        chk("reset_data", 32'(tx_data), 32'd0);
        chk("reset_hs", 32'({in_ready, credit_ack}), 32'd0);
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
        chk("reset_stat_words", stat_words, 32'd0);
        chk("reset_stat_esc", 32'(stat_escapes), 32'd0);
`endif
        rst = 1'b1;
        step();

        // Escaped high byte, then escaped low byte
        send_word("w_fe05", 16'hFE05);
        do_byte("fe05_b0", 8'hFE, 2);
        do_byte("fe05_b1", 8'hFE, 2);
        do_byte("fe05_b2", 8'h05, 2);
        chk("fe05_idle", 32'(tx_enable), 32'd0);
        send_word("w_00fe", 16'h00FE);
        do_byte("00fe_b0", 8'h00, 1);
        do_byte("00fe_b1", 8'hFE, 1);
        do_byte("00fe_b2", 8'hFE, 1);
        chk("00fe_idle", 32'(tx_enable), 32'd0);
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
        chk("stat_words_2", stat_words, 32'd2);
        chk("stat_esc_2", 32'(stat_escapes), 32'd2);
`endif

        // Plain word, done returned 3 cycles after each byte
        send_word("w_1234", 16'h1234);
        do_byte("1234_hi", 8'h12, 2);
        do_byte("1234_lo", 8'h34, 2);
        chk("1234_idle", 32'(tx_enable), 32'd0);
        chk("1234_no_ready", 32'(in_ready), 32'd0);

        // Credit and word in the same cycle: credit wins, raw credit bytes
        credit_val = 15'h7EFE;
        credit_req = 1'b1;
        in_data    = 16'hAAAA;
        in_valid   = 1'b1;
        #1;
        chk("prio_credit_ack", 32'(credit_ack), 32'd1);
        chk("prio_in_ready", 32'(in_ready), 32'd0);
        step();
        credit_req = 1'b0;
        do_byte("cr1_esc", 8'hFE, 1);
        do_byte("cr1_cmd", 8'h01, 1);
        do_byte("cr1_hi", 8'h7E, 1);
        do_byte("cr1_lo", 8'hFE, 1);
        chk("cr1_idle", 32'(tx_enable), 32'd0);
        chk("aaaa_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        do_byte("aaaa_hi", 8'hAA, 0);
        do_byte("aaaa_lo", 8'hAA, 0);
        chk("aaaa_idle", 32'(tx_enable), 32'd0);

        // Credit request mid-word waits for the word to finish
        send_word("w_beef", 16'hBEEF);
        credit_val = 15'h0123;
        credit_req = 1'b1;
        do_byte("beef_hi", 8'hBE, 1);
        do_byte("beef_lo", 8'hEF, 1);
        chk("cr2_ack", 32'(credit_ack), 32'd1);
        step();
        credit_req = 1'b0;
        do_byte("cr2_esc", 8'hFE, 0);
        do_byte("cr2_cmd", 8'h01, 0);
        do_byte("cr2_hi", 8'h01, 0);
        do_byte("cr2_lo", 8'h23, 0);
        chk("cr2_idle", 32'(tx_enable), 32'd0);

        // Stray tx_done in IDLE is ignored
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        chk("stray_done_idle", 32'(tx_enable), 32'd0);

        // Long hold of a byte with a pending word
        send_word("w_1357", 16'h1357);
        in_data  = 16'h2468;
        in_valid = 1'b1;
        do_byte("1357_hi", 8'h13, 100);
        do_byte("1357_lo", 8'h57, 0);
        chk("2468_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        do_byte("2468_hi", 8'h24, 0);
        do_byte("2468_lo", 8'h68, 0);
        chk("2468_idle", 32'(tx_enable), 32'd0);

        // Async reset during the low byte discards the word
        send_word("w_5566", 16'h5566);
        do_byte("5566_hi", 8'h55, 1);
        chk("5566_lo_present", 32'({tx_enable, tx_data}), 32'({1'b1, 8'h66}));
        #3;
        rst = 1'b0;
        #1;
        chk("abort_en", 32'(tx_enable), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_reset_idle", 32'(tx_enable), 32'd0);
        send_word("w_7788", 16'h7788);
        do_byte("7788_hi", 8'h77, 1);
        do_byte("7788_lo", 8'h88, 1);
        chk("7788_idle", 32'(tx_enable), 32'd0);
        step();
        chk("7788_stay_idle", 32'(tx_enable), 32'd0);
`ifdef GLIP_UART_TX_FRAMER_STATS_EN
        chk("stat_words_end", stat_words, 32'd1);
        chk("stat_esc_end", 32'(stat_escapes), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
